// File: rtl/serial_paralelo_align_pkg.sv
// Shared definitions for the serial lane: sync state encoding and default comma.
// The lane serialiser relies on the same values.
package serial_paralelo_align_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } sync_st_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/serial_paralelo_align_shift_window.sv
// Serial shift register, sampling window and word-boundary bit counter.
// reload restarts the count so the next boundary lands WIDTH cycles later.
module serial_shift_window #(
  parameter int WIDTH = 8
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  input  logic             reload,
  output logic [WIDTH-1:0] win,
  output logic             boundary
);
  localparam int BW = $clog2(WIDTH);

  // Only WIDTH-1 history bits are needed; the newest bit comes straight from data_in.
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]    bit_cnt;

  assign win      = {sr, data_in};
  assign boundary = (bit_cnt == BW'(WIDTH-1));

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr <= win[WIDTH-2:0];
      if (reload || boundary) bit_cnt <= '0;
      else                    bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel lane receiver: hunts for the comma, verifies alignment,
// then delivers non-comma words with a one-cycle strobe until alignment is lost.
module serial_paralelo_align
  import serial_paralelo_align_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] COMMA         = WIDTH'(COMMA_DEFAULT),
  parameter int               ACTIVE_THRESH = 4,
  parameter int               MISALIGN_MAX  = 3
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active,
  output logic [1:0]       sync_state
);
  localparam int CW = $clog2(ACTIVE_THRESH+1);
  localparam int MW = $clog2(MISALIGN_MAX+1);

  sync_st_t         state, state_nxt;
  logic [CW-1:0]    comma_cnt, comma_nxt;
  logic [MW-1:0]    misalign_cnt, misalign_nxt;
  logic [WIDTH-1:0] win;
  logic             boundary, reload, emit, is_comma;

  serial_shift_window #(.WIDTH(WIDTH)) u_win (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .reload   (reload),
    .win      (win),
    .boundary (boundary)
  );

  assign is_comma   = (win == COMMA);
  assign sync_state = state;

  always_comb begin
    state_nxt    = state;
    comma_nxt    = comma_cnt;
    misalign_nxt = misalign_cnt;
    reload       = 1'b0;
    emit         = 1'b0;
    unique case (state)
      ST_HUNT: begin
        if (is_comma) begin
          reload    = 1'b1;
          comma_nxt = CW'(1);
          state_nxt = (ACTIVE_THRESH == 1) ? ST_ACTIVE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (!is_comma) begin
            state_nxt = ST_HUNT;
            comma_nxt = '0;
          end else if (comma_cnt >= CW'(ACTIVE_THRESH-1)) begin
            comma_nxt = CW'(ACTIVE_THRESH);
            state_nxt = ST_ACTIVE;
          end else begin
            comma_nxt = comma_cnt + CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          if (is_comma) misalign_nxt = '0;
          else          emit         = 1'b1;
        end else if (is_comma) begin
          // A comma off the established boundary means the lane has slipped.
          if (misalign_cnt >= MW'(MISALIGN_MAX-1)) begin
            state_nxt    = ST_HUNT;
            comma_nxt    = '0;
            misalign_nxt = '0;
            reload       = 1'b1;
          end else begin
            misalign_nxt = misalign_cnt + MW'(1);
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state        <= ST_HUNT;
      comma_cnt    <= '0;
      misalign_cnt <= '0;
      active       <= 1'b0;
      valid_out    <= 1'b0;
      data_out     <= '0;
    end else begin
      state        <= state_nxt;
      comma_cnt    <= comma_nxt;
      misalign_cnt <= misalign_nxt;
      active       <= (state_nxt == ST_ACTIVE);
      valid_out    <= emit;
      if (emit) data_out <= win;
    end
  end

endmodule
